vec_sequencer: RTL
==================

Name: vec_sequencer

Overview:
- Multi-cycle control sequencer for the vector/scalar core.
- Fetches 16-bit instructions over a ready-handshaked instruction port and holds each one stable for the instruction decoder.
- Consumes the decoder's functype and cycle count, then times execution and element-serial vector memory transfers.
- Issues the register-file write strobes and retires the instruction by advancing the PC.

Parameters:
PC_W, 16, program counter width
VLEN, 16, elements per vector register
IDX_W, 4, element index width (log2 VLEN)

Ports:
clk  in  1  core clock
rst  in  1  reset (described under Behaviour)
start  in  1  begin execution at pc=0 (level, sampled in IDLE)
imem_req  out  1  instruction fetch request
imem_rdy  in  1  instruction valid on instr_in this cycle
instr_in  in  16  fetched instruction word
instr  out  16  latched instruction, drives decoder
functype  in  4  opcode from decoder (instr[15:12])
cycle_count  in  5  execution cycles from decoder
pc  out  PC_W  address of current/next instruction
dmem_req  out  1  data memory element request
dmem_we  out  1  1 = store beat, 0 = load beat
dmem_rdy  in  1  data memory accepted/returned current element
elem_idx  out  IDX_W  current vector element
v_wr  out  1  vector register file write strobe
s_wr  out  1  scalar register file write strobe
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT

Behaviour:
- Reset is synchronous and active-high: one clock; rst sampled on the rising edge of clk only.
- Reset values: state=IDLE, pc=0, instr=16'hF000 (NOP), all strobes 0, elem_idx=0, counter=0.
- rst mid-operation aborts any fetch, exec or memory burst on the next edge. No further strobes are issued.
- Opcodes: VADD 0, VDOT 1, SMUL 2, SST 3, VLD 4, VST 5, SLL 6, SLH 7, HALT E, NOP F. Unlisted opcodes execute as NOP.
- IDLE: wait for start=1, then go to FETCH. start in any other state is ignored.
- FETCH:
  - imem_req=1.
  - On imem_rdy=1: instr<=instr_in, go to DECODE.
  - Stalls indefinitely while imem_rdy=0.
- DECODE:
  - One cycle; decoder outputs settle from the latched instr.
  - counter <= cycle_count; a value of 0 is loaded as 1.
  - Next state: VLD/VST -> MEM with elem_idx=0. HALT -> HALT. Otherwise -> EXEC.
- EXEC:
  - counter decrements each cycle.
  - On the cycle counter==1: s_wr=1 for SLL/SLH, v_wr=1 for VADD. The strobe is a one-cycle pulse.
  - Same cycle: pc<=pc+1, go to FETCH.
  - NOP and unlisted opcodes retire the same way with no strobes.
- MEM:
  - dmem_req=1 throughout. dmem_we=1 for VST, 0 for VLD.
  - A beat completes on a cycle with dmem_rdy=1.
  - VLD: v_wr=1 on each completing beat; the write lands at elem_idx.
  - Each beat: elem_idx increments. Beat VLEN-1 wraps elem_idx to 0, then pc<=pc+1 and go to FETCH.
  - dmem_rdy=0 holds elem_idx and state; dmem_req stays high.
  - Exactly VLEN beats per VLD/VST.
- HALT: pc frozen, all requests/strobes 0, halted=1. Exit only via rst.
- pc arithmetic is modulo 2^PC_W: all-ones increments to 0.
- Strobe exclusivity: v_wr and s_wr are never high together. Neither is high in IDLE, FETCH, DECODE or HALT.
- Total latency per instruction, with ready inputs always high:
  - non-memory: 3 + (cycle_count-1) cycles (FETCH+DECODE+EXEC)
  - VLD/VST: 2 + VLEN cycles.

Test Plan:
- Reset and idle: assert rst 2 cycles, start=0 -> pc=0, busy=0, imem_req=0, instr=16'hF000 held for 10 cycles.
- VADD retire: start=1, imem_rdy=1, instr_in=16'h0A98 -> FETCH, DECODE, EXEC. Single v_wr pulse in EXEC; pc=1 on the next fetch; 3 cycles total.
- VLD with stalls: instr_in=16'h4243. dmem_rdy toggles 1,0,1,0... -> dmem_we=0, elem_idx 0..15, exactly 16 v_wr pulses. Each pulse coincides with dmem_rdy=1; pc increments once after beat 15.
- VST: instr_in=16'h5600, dmem_rdy=1 -> 16 cycles of dmem_req=1 and dmem_we=1, no v_wr/s_wr, elem_idx wraps to 0.
- SLL then HALT, with imem_rdy held low 5 cycles before the HALT fetch -> one s_wr pulse, fetch stalls without state change, halted=1, pc frozen at 1. Further start pulses are ignored.
- Reset mid-VLD at elem_idx=7 -> next cycle state=IDLE, pc=0, dmem_req=0, no further v_wr. Restart with start reruns from pc=0.

Source files
------------

// File: rtl/vec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_sequencer: fetch/decode/exec/mem control sequencer for the core  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vec_sequencer #(
  parameter int PC_W  = 16,
  parameter int VLEN  = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_rdy,
  input  logic [15:0]      instr_in,
  output logic [15:0]      instr,
  input  logic [3:0]       functype,
  input  logic [4:0]       cycle_count,
  output logic [PC_W-1:0]  pc,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_rdy,
  output logic [IDX_W-1:0] elem_idx,
  output logic             v_wr,
  output logic             s_wr,
  output logic             busy,
  output logic             halted
);

  localparam logic [3:0]       c_op_vadd  = 4'h0;
  localparam logic [3:0]       c_op_vld   = 4'h4;
  localparam logic [3:0]       c_op_vst   = 4'h5;
  localparam logic [3:0]       c_op_sll   = 4'h6;
  localparam logic [3:0]       c_op_slh   = 4'h7;
  localparam logic [3:0]       c_op_halt  = 4'hE;
  localparam logic [15:0]      c_nop_word = 16'hF000;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(VLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [PC_W-1:0]  r_pc,        w_pc_nxt;
  logic [15:0]      r_instr,     w_instr_nxt;
  logic [4:0]       r_counter,   w_counter_nxt;
  logic [IDX_W-1:0] r_elem_idx,  w_elem_idx_nxt;
  logic             w_imem_req, w_dmem_req, w_dmem_we, w_v_wr, w_s_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= c_nop_word;
      r_counter  <= '0;
      r_elem_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_counter  <= w_counter_nxt;
      r_elem_idx <= w_elem_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_counter_nxt  = r_counter;
    w_elem_idx_nxt = r_elem_idx;
    w_imem_req     = 1'b0;
    w_dmem_req     = 1'b0;
    w_dmem_we      = 1'b0;
    w_v_wr         = 1'b0;
    w_s_wr         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_rdy) begin
          w_instr_nxt = instr_in;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // A zero-cycle op still needs one EXEC cycle to retire.
        w_counter_nxt  = (cycle_count == 5'd0) ? 5'd1 : cycle_count;
        w_elem_idx_nxt = '0;
        case (functype)
          c_op_vld, c_op_vst: w_state_nxt = S_MEM;
          c_op_halt:          w_state_nxt = S_HALT;
          default:            w_state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_counter_nxt = r_counter - 5'd1;
        if (r_counter == 5'd1) begin
          w_v_wr      = (functype == c_op_vadd);
          w_s_wr      = (functype == c_op_sll) || (functype == c_op_slh);
          w_pc_nxt    = r_pc + PC_W'(1);
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (functype == c_op_vst);
        if (dmem_rdy) begin
          w_v_wr = (functype == c_op_vld);
          if (r_elem_idx == c_last_idx) begin
            w_elem_idx_nxt = '0;
            w_pc_nxt       = r_pc + PC_W'(1);
            w_state_nxt    = S_FETCH;
          end else begin
            w_elem_idx_nxt = r_elem_idx + IDX_W'(1);
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_req = w_imem_req;
  assign dmem_req = w_dmem_req;
  assign dmem_we  = w_dmem_we;
  assign v_wr     = w_v_wr;
  assign s_wr     = w_s_wr;
  assign instr    = r_instr;
  assign pc       = r_pc;
  assign elem_idx = r_elem_idx;
  assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted   = (r_state == S_HALT);

endmodule
`default_nettype wire
